// File: rtl/tl_timing_sequencer.sv
// Timing-profile sequencer for the traffic-light controller: holds four {num, duty}
// profiles and switches the active one at a green-lamp rising edge or after a timeout.
module tl_timing_sequencer #(
  parameter int DEF_NUM  = 2,
  parameter int DEF_DUTY = 3,
  parameter int INIT_NUM = 2,
  parameter int TIMEOUT  = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [1:0] wr_profile,
  input  logic [2:0] wr_num,
  input  logic [2:0] wr_duty,
  output logic       wr_ready,
  input  logic [1:0] profile_sel,
  input  logic       green_in,
  output logic [2:0] num,
  output logic [2:0] duty_cycle,
  output logic [2:0] initNum,
  output logic       load,
  output logic [1:0] active_profile,
  output logic       wr_err
);

  // state  | meaning
  // INIT   | after reset, loads profile 0 on the next cycle
  // IDLE   | outputs stable, writes accepted, watching for a profile mismatch
  // PEND   | switch requested, waiting for green rising edge or timeout
  // LOAD   | outputs just updated, load pulse high
  localparam logic [1:0] S_INIT = 2'd0;
  localparam logic [1:0] S_IDLE = 2'd1;
  localparam logic [1:0] S_PEND = 2'd2;
  localparam logic [1:0] S_LOAD = 2'd3;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [1:0] state_q, state_d;
  logic [1:0] pend_q, pend_d;
  logic [7:0] wait_q, wait_d;
  logic       green_q;
  logic [2:0] num_q, duty_q;
  logic [1:0] act_q;
  logic       load_q, err_q;
  logic [2:0] tbl_num_q  [4];
  logic [2:0] tbl_duty_q [4];

  logic       wr_hit, wr_acc, green_rise;
  logic [1:0] ld_idx;

  assign wr_ready   = (state_q == S_IDLE);
  assign wr_hit     = wr_en & wr_ready;
  assign wr_acc     = wr_hit & (wr_duty != 3'd0);
  assign green_rise = green_in & ~green_q;
  assign ld_idx     = (state_q == S_INIT) ? 2'd0 : pend_q;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    wait_d  = 8'd0;
    case (state_q)
      S_INIT: state_d = S_LOAD;
      S_IDLE: begin
        // a new selection outranks a rewrite of the active profile
        if (profile_sel != act_q) begin
          state_d = S_PEND;
          pend_d  = profile_sel;
        end else if (wr_acc && (wr_profile == act_q)) begin
          state_d = S_PEND;
          pend_d  = act_q;
        end
      end
      S_PEND: begin
        wait_d = wait_q + 8'd1;
        if (green_rise || (wait_q == WAIT_LAST)) state_d = S_LOAD;
      end
      S_LOAD:  state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      pend_q  <= 2'd0;
      wait_q  <= 8'd0;
      green_q <= 1'b0;
      num_q   <= 3'(DEF_NUM);
      duty_q  <= 3'(DEF_DUTY);
      act_q   <= 2'd0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        tbl_num_q[i]  <= 3'(DEF_NUM);
        tbl_duty_q[i] <= 3'(DEF_DUTY);
      end
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      wait_q  <= wait_d;
      green_q <= green_in;
      load_q  <= (state_d == S_LOAD);
      err_q   <= wr_hit & (wr_duty == 3'd0);
      if (wr_acc) begin
        tbl_num_q[wr_profile]  <= wr_num;
        tbl_duty_q[wr_profile] <= wr_duty;
      end
      if (state_d == S_LOAD) begin
        num_q  <= tbl_num_q[ld_idx];
        duty_q <= tbl_duty_q[ld_idx];
        act_q  <= ld_idx;
      end
    end
  end

  assign num            = num_q;
  assign duty_cycle     = duty_q;
  assign initNum        = 3'(INIT_NUM);
  assign load           = load_q;
  assign active_profile = act_q;
  assign wr_err         = err_q;

endmodule

// File: doc/tl_timing_sequencer.md
TL_TIMING_SEQUENCER -- requirements
Module: tl_timing_sequencer

Interface
REQ-001 Parameters SHALL be: DEF_NUM, default 2, num value loaded into every profile at reset.
REQ-002 Parameters SHALL be: DEF_DUTY, default 3, duty_cycle value loaded into every profile at reset.
REQ-003 Parameters SHALL be: INIT_NUM, default 2, constant driven on initNum.
REQ-004 Parameters SHALL be: TIMEOUT, default 15, max cycles (1..255) waiting for a safe point before a forced switch.
REQ-005 Port clk SHALL be an input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 Port rst_n SHALL be an input, 1 bit: synchronous, active-low reset.
REQ-007 Port wr_en SHALL be an input, 1 bit: profile write request, accepted only when wr_ready=1.
REQ-008 Port wr_profile SHALL be an input, 2 bits: index of the profile being written.
REQ-009 Port wr_num SHALL be an input, 3 bits: low-phase count to write.
REQ-010 Port wr_duty SHALL be an input, 3 bits: high-phase count to write.
REQ-011 Port wr_ready SHALL be an output, 1 bit: write acceptance (1 only in IDLE).
REQ-012 Port profile_sel SHALL be an input, 2 bits: requested active profile.
REQ-013 Port green_in SHALL be an input, 1 bit: green lamp fed back from the traffic light controller.
REQ-014 Port num SHALL be an output, 3 bits: registered num to the controller.
REQ-015 Port duty_cycle SHALL be an output, 3 bits: registered duty_cycle to the controller.
REQ-016 Port initNum SHALL be an output, 3 bits: counter init value, always INIT_NUM.
REQ-017 Port load SHALL be an output, 1 bit: one-cycle registered counter-load pulse.
REQ-018 Port active_profile SHALL be an output, 2 bits: index currently driven on num/duty_cycle.
REQ-019 Port wr_err SHALL be an output, 1 bit: one-cycle pulse on a rejected write.

Function
REQ-020 Storage SHALL be a 4-entry table of {num[2:0], duty[2:0]}.
REQ-021 FSM states SHALL be INIT, IDLE, PEND, LOAD.
REQ-022 INIT SHALL be entered on reset and SHALL go to LOAD on the next cycle, so the first load pulse appears 2 cycles after rst_n rises.
REQ-023 A write SHALL be accepted when wr_en=1, wr_ready=1 and wr_duty!=0; the table is updated on that edge.
REQ-024 When wr_en=1, wr_ready=1 and wr_duty==0, the table SHALL be unchanged and wr_err SHALL be 1 on the next cycle.
REQ-025 wr_en while wr_ready=0 SHALL be ignored: no update, no wr_err.
REQ-026 In IDLE, the FSM SHALL go to PEND, latching pend_idx=profile_sel, when profile_sel!=active_profile, or when an accepted write targets active_profile (pend_idx=active_profile).
REQ-027 If profile_sel changes and an accepted write occur together, the profile_sel request SHALL take priority.
REQ-028 In PEND, a 0->1 edge of green_in (registered previous value compared to current) SHALL move the FSM to LOAD.
REQ-029 In PEND, an 8-bit wait counter SHALL clear on entry and increment each cycle; on reaching TIMEOUT-1 the FSM SHALL move to LOAD regardless of green_in.
REQ-030 Changes to profile_sel during PEND SHALL NOT retarget pend_idx; a new mismatch is handled after returning to IDLE.
REQ-031 On entry to LOAD, num, duty_cycle and active_profile SHALL be updated from pend_idx (INIT uses profile 0), and load SHALL be 1 for exactly that one cycle.
REQ-032 LOAD SHALL always return to IDLE.
REQ-033 Outputs SHALL be stable except at LOAD entry.
REQ-034 No arithmetic SHALL exceed 3 bits per field; table values pass through unmodified.

Reset
REQ-035 While rst_n=0 at a clk edge: all table entries = {DEF_NUM, DEF_DUTY}, num=DEF_NUM, duty_cycle=DEF_DUTY, active_profile=0, load=0, wr_err=0, wr_ready=0, wait counter=0, green_in history=0, state=INIT.
REQ-036 A reset asserted mid-PEND or mid-LOAD SHALL abandon the switch, leaving no residual load pulse.

Verification
REQ-037 Reset release -> load=1 exactly at cycle 2, num=2, duty_cycle=3, initNum=2, active_profile=0.
REQ-038 Write profile 1 {num=4, duty=1}, then profile_sel=1 with green_in low, rising 3 cycles later -> load pulse one cycle after the green edge, num=4, duty_cycle=1, active_profile=1.
REQ-039 profile_sel=2 with green_in held 0, TIMEOUT=15 -> load exactly 15 cycles after PEND entry, active_profile=2.
REQ-040 Write with wr_duty=0 -> wr_err pulse, table unchanged; wr_en during PEND -> ignored, wr_ready=0.
REQ-041 Write to active profile 0 {num=1, duty=5} in IDLE -> PEND, then load with num=1, duty_cycle=5 on the next green rise.
REQ-042 rst_n=0 during PEND -> no load pulse before the post-reset INIT load; defaults restored.
